// File: rtl/ingress_port_arbiter.sv
// rtl/ingress_port_arbiter.sv - round-robin frame arbiter for four ingress ports
//
// Shares one frame-processing pipeline between four per-port receive
// channels. Each port provides a byte FIFO and a descriptor FIFO. The arbiter
// locks onto one port for a whole frame and presents that port's FIFOs to the
// frame processor as a single sfifo / ptr_sfifo pair.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   port_ptr_empty    per-port descriptor FIFO empty flags
//   port_ptr_dout     per-port descriptor data, port i at [i*PTR_W +: PTR_W]
//   port_ptr_rd       per-port descriptor FIFO read strobes
//   port_dout         per-port byte data, port i at [i*8 +: 8]
//   port_rd           per-port byte FIFO read strobes
//   ptr_sfifo_rd      descriptor read from the frame processor
//   ptr_sfifo_dout    granted descriptor with source-portmap stamped in [15:12]
//   ptr_sfifo_empty   descriptor-empty as seen by the frame processor
//   sfifo_rd          byte read from the frame processor
//   sfifo_dout        granted port's byte data
//   grant             one-hot current owner, 0 while idle
//   frame_bytes       byte count of the last completed frame
//   len_err           one-cycle pulse when a frame was read short

module ingress_port_arbiter #(
  parameter int NPORT = 4,
  parameter int PTR_W = 20,
  parameter int LEN_W = 11
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NPORT-1:0]       port_ptr_empty,
  input  logic [NPORT*PTR_W-1:0] port_ptr_dout,
  output logic [NPORT-1:0]       port_ptr_rd,
  input  logic [NPORT*8-1:0]     port_dout,
  output logic [NPORT-1:0]       port_rd,
  input  logic                   ptr_sfifo_rd,
  output logic [PTR_W-1:0]       ptr_sfifo_dout,
  output logic                   ptr_sfifo_empty,
  input  logic                   sfifo_rd,
  output logic [7:0]             sfifo_dout,
  output logic [NPORT-1:0]       grant,
  output logic [LEN_W-1:0]       frame_bytes,
  output logic                   len_err
);

  localparam int IDX_W    = $clog2(NPORT);
  // Source-portmap field inside the descriptor.
  localparam int PMAP_LSB = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HDR   = 2'd2,
    XFER  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NPORT-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               rd_seen_q, rd_seen_d;
  logic [PTR_W-1:0]   ptr_hold_q, ptr_hold_d;
  logic [LEN_W-1:0]   frame_bytes_q, frame_bytes_d;
  logic               len_err_q, len_err_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic [PTR_W-1:0]   ptr_mux;
  logic [PTR_W-1:0]   ptr_stamped;
  logic [LEN_W-1:0]   cnt_inc;

  // Round-robin search starting at last+1. Walking the offsets from the
  // farthest to the nearest lets the nearest requester overwrite the others,
  // so last+1 has the highest priority and last itself the lowest.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NPORT; k >= 1; k--) begin
      cand = last_q + IDX_W'(k);
      if (!port_ptr_empty[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Descriptor of the owning port with the one-hot grant stamped over the
  // source-portmap field, so downstream always sees where the frame came from.
  always_comb begin
    ptr_mux     = port_ptr_dout[int'(owner_q)*PTR_W +: PTR_W];
    ptr_stamped = ptr_mux;
    ptr_stamped[PMAP_LSB +: NPORT] = grant_q;
  end

  // Byte counter saturates instead of wrapping on oversize frames.
  assign cnt_inc = (cnt_q == {LEN_W{1'b1}}) ? cnt_q : cnt_q + LEN_W'(1);

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    grant_d         = grant_q;
    last_d          = last_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    rd_seen_d       = rd_seen_q;
    ptr_hold_d      = ptr_hold_q;
    frame_bytes_d   = frame_bytes_q;
    len_err_d       = 1'b0;
    ptr_sfifo_empty = 1'b1;
    ptr_sfifo_dout  = ptr_hold_q;
    port_ptr_rd     = '0;
    port_rd         = '0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          grant_d = NPORT'(1) << pick_idx;
          state_d = GRANT;
        end
      end

      GRANT: begin
        ptr_sfifo_empty = port_ptr_empty[owner_q];
        port_ptr_rd     = grant_q & {NPORT{ptr_sfifo_rd}};
        if (ptr_sfifo_rd) begin
          state_d = HDR;
        end
      end

      // Upstream descriptor FIFO is non-FWFT: the word read in GRANT is on
      // port_ptr_dout now. Capture it so ptr_sfifo_dout holds afterwards.
      HDR: begin
        ptr_sfifo_dout = ptr_stamped;
        ptr_hold_d     = ptr_stamped;
        len_d          = ptr_mux[LEN_W-1:0];
        cnt_d          = '0;
        rd_seen_d      = 1'b0;
        state_d        = XFER;
      end

      // ptr_sfifo_empty stays high so a second descriptor cannot be pulled
      // mid-frame. The frame ends on the first idle sfifo_rd after a read.
      XFER: begin
        port_rd = grant_q & {NPORT{sfifo_rd}};
        if (sfifo_rd) begin
          cnt_d     = cnt_inc;
          rd_seen_d = 1'b1;
        end else if (rd_seen_q) begin
          frame_bytes_d = cnt_q;
          len_err_d     = (cnt_q < len_q);
          last_d        = owner_q;
          grant_d       = '0;
          state_d       = IDLE;
        end
      end

      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      grant_q       <= '0;
      last_q        <= IDX_W'(NPORT - 1);
      len_q         <= '0;
      cnt_q         <= '0;
      rd_seen_q     <= 1'b0;
      ptr_hold_q    <= '0;
      frame_bytes_q <= '0;
      len_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      rd_seen_q     <= rd_seen_d;
      ptr_hold_q    <= ptr_hold_d;
      frame_bytes_q <= frame_bytes_d;
      len_err_q     <= len_err_d;
    end
  end

  assign grant       = grant_q;
  assign sfifo_dout  = port_dout[int'(owner_q)*8 +: 8];
  assign frame_bytes = frame_bytes_q;
  assign len_err     = len_err_q;

endmodule

// File: tb/tb_ingress_port_arbiter.sv
// tb/tb_ingress_port_arbiter.sv - self-checking bench for ingress_port_arbiter

module tb_ingress_port_arbiter;

  localparam int NPORT = 4;
  localparam int PTR_W = 20;
  localparam int LEN_W = 11;
  localparam int LEN_MAX = (1 << LEN_W) - 1;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic [NPORT-1:0]       port_ptr_empty;
  logic [NPORT*PTR_W-1:0] port_ptr_dout;
  logic [NPORT-1:0]       port_ptr_rd;
  logic [NPORT*8-1:0]     port_dout;
  logic [NPORT-1:0]       port_rd;
  logic                   ptr_sfifo_rd;
  logic [PTR_W-1:0]       ptr_sfifo_dout;
  logic                   ptr_sfifo_empty;
  logic                   sfifo_rd;
  logic [7:0]             sfifo_dout;
  logic [NPORT-1:0]       grant;
  logic [LEN_W-1:0]       frame_bytes;
  logic                   len_err;

  ingress_port_arbiter #(.NPORT(NPORT), .PTR_W(PTR_W), .LEN_W(LEN_W)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .port_ptr_empty  (port_ptr_empty),
    .port_ptr_dout   (port_ptr_dout),
    .port_ptr_rd     (port_ptr_rd),
    .port_dout       (port_dout),
    .port_rd         (port_rd),
    .ptr_sfifo_rd    (ptr_sfifo_rd),
    .ptr_sfifo_dout  (ptr_sfifo_dout),
    .ptr_sfifo_empty (ptr_sfifo_empty),
    .sfifo_rd        (sfifo_rd),
    .sfifo_dout      (sfifo_dout),
    .grant           (grant),
    .frame_bytes     (frame_bytes),
    .len_err         (len_err)
  );

  always #5 clk = ~clk;

  // Upstream descriptor FIFOs: non-FWFT, data appears the cycle after a read.
  logic [PTR_W-1:0] dmem [NPORT][256];
  int               wr_cnt [NPORT];
  int               rd_cnt [NPORT];

  always_comb begin
    for (int p = 0; p < NPORT; p++) port_ptr_empty[p] = (wr_cnt[p] == rd_cnt[p]);
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_cnt        <= '{default: 0};
      port_ptr_dout <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (port_ptr_rd[p] && (rd_cnt[p] != wr_cnt[p])) begin
          port_ptr_dout[p*PTR_W +: PTR_W] <= dmem[p][8'(rd_cnt[p])];
          rd_cnt[p] <= rd_cnt[p] + 1;
        end
      end
    end
  end

  // Reference model: pending descriptors per port and the previous owner.
  logic [PTR_W-1:0] exp_q [NPORT][$];
  int               last_m;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int p, input int len);
    logic [PTR_W-1:0] d;
    d = PTR_W'($urandom);
    d[10:0] = 11'(len);
    dmem[p][8'(wr_cnt[p])] = d;
    wr_cnt[p] = wr_cnt[p] + 1;
    exp_q[p].push_back(d);
  endtask

  task automatic model_reset();
    for (int p = 0; p < NPORT; p++) begin
      exp_q[p].delete();
      wr_cnt[p] = 0;
    end
    last_m = NPORT - 1;
  endtask

  function automatic int pick();
    for (int k = 1; k <= NPORT; k++) begin
      if (exp_q[(last_m + k) % NPORT].size() > 0) return (last_m + k) % NPORT;
    end
    return -1;
  endfunction

  task automatic arb_wait(output bit ok);
    int waitc;
    waitc = 0;
    while (ptr_sfifo_empty !== 1'b0 && waitc < 10) begin
      @(negedge clk); #1;
      waitc++;
    end
    chk("arb_wait", 32'(ptr_sfifo_empty), 32'(0));
    ok = (ptr_sfifo_empty === 1'b0);
  endtask

  // Frame processor: read one descriptor, then nrd bytes back to back.
  task automatic do_frame(input int nrd, input bit spur);
    int               g, len, seen, sat;
    bit               ok;
    logic [PTR_W-1:0] desc, exp_dout;
    logic [NPORT-1:0] oh;
    g = pick();
    if (g < 0) return;
    desc = exp_q[g].pop_front();
    oh   = NPORT'(1 << g);
    len  = int'(desc[10:0]);
    exp_dout = {desc[19:16], oh, desc[11:0]};
    arb_wait(ok);
    if (!ok) return;
    chk("grant", 32'(grant), 32'(oh));
    ptr_sfifo_rd = 1'b1;
    sfifo_rd     = spur;
    #1;
    chk("port_ptr_rd", 32'(port_ptr_rd), 32'(oh));
    chk("grant_port_rd", 32'(port_rd), 32'(0));
    @(negedge clk);
    ptr_sfifo_rd = 1'b0;
    sfifo_rd     = 1'b0;
    #1;
    chk("hdr_dout", 32'(ptr_sfifo_dout), 32'(exp_dout));
    chk("hdr_grant", 32'(grant), 32'(oh));
    seen = 0;
    for (int i = 0; i < nrd; i++) begin
      @(negedge clk);
      sfifo_rd     = 1'b1;
      ptr_sfifo_rd = spur;
      port_dout    = {$urandom, $urandom} [NPORT*8-1:0];
      #1;
      if (port_rd[g]) seen++;
      if (i == 0 || i == nrd - 1) begin
        chk("xfer_empty", 32'(ptr_sfifo_empty), 32'(1));
        chk("xfer_port_rd", 32'(port_rd), 32'(oh));
        chk("xfer_grant", 32'(grant), 32'(oh));
        chk("sfifo_dout", 32'(sfifo_dout), 32'(port_dout[g*8 +: 8]));
      end
      if (spur) chk("spur_ptr_rd", 32'(port_ptr_rd), 32'(0));
    end
    @(negedge clk);
    sfifo_rd     = 1'b0;
    ptr_sfifo_rd = 1'b0;
    #1;
    chk("rd_pulses", 32'(seen), 32'(nrd));
    @(negedge clk); #1;
    sat = (nrd > LEN_MAX) ? LEN_MAX : nrd;
    chk("frame_bytes", 32'(frame_bytes), 32'(sat));
    chk("len_err", 32'(len_err), 32'(sat < len));
    chk("idle_grant", 32'(grant), 32'(0));
    chk("hold_dout", 32'(ptr_sfifo_dout), 32'(exp_dout));
    @(negedge clk); #1;
    chk("len_err_pulse", 32'(len_err), 32'(0));
    last_m = g;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int len, r, nrd;
    ptr_sfifo_rd = 1'b0;
    sfifo_rd     = 1'b0;
    port_dout    = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_empty", 32'(ptr_sfifo_empty), 32'(1));
    chk("rst_dout", 32'(ptr_sfifo_dout), 32'(0));
    chk("rst_frame_bytes", 32'(frame_bytes), 32'(0));
    chk("rst_len_err", 32'(len_err), 32'(0));
    chk("rst_strobes", 32'({port_rd, port_ptr_rd}), 32'(0));
    @(negedge clk);
    rstn = 1'b1;

    // Single frame on port 2.
    @(negedge clk);
    push(2, 64);
    do_frame(64, 1'b0);

    // Simultaneous requests on ports 0, 1, 3, then port 0 re-requests.
    push(0, 8); push(1, 12); push(3, 5);
    do_frame(8, 1'b0); do_frame(12, 1'b0); do_frame(5, 1'b0);
    push(0, 3);
    do_frame(3, 1'b0);

    // Two continuously busy ports must alternate.
    for (int i = 0; i < 3; i++) begin
      push(0, 4 + i); push(1, 6 + i);
    end
    for (int i = 0; i < 6; i++) do_frame(4 + i / 2 + 2 * (i % 2), 1'b0);

    // Short read, overrun and counter saturation.
    push(1, 100);  do_frame(90, 1'b0);
    push(3, 10);   do_frame(15, 1'b0);
    push(0, 2047); do_frame(2050, 1'b0);

    // Spurious strobes while idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sfifo_rd = 1'b1; ptr_sfifo_rd = 1'b1;
      #1;
      chk("idle_spur_rd", 32'({port_rd, port_ptr_rd}), 32'(0));
      chk("idle_spur_grant", 32'(grant), 32'(0));
    end
    @(negedge clk);
    sfifo_rd = 1'b0; ptr_sfifo_rd = 1'b0;

    // Spurious strobes inside a frame with another port waiting.
    push(2, 20); push(1, 5);
    do_frame(20, 1'b1); do_frame(5, 1'b0);

    // Randomized batches.
    for (int b = 0; b < 8; b++) begin
      for (int p = 0; p < NPORT; p++) begin
        for (int n = int'($urandom_range(0, 2)); n > 0; n--) push(p, int'($urandom_range(1, 60)));
      end
      while (pick() >= 0) begin
        len = int'(exp_q[pick()][0][10:0]);
        r   = int'($urandom_range(0, 2));
        nrd = (r == 0) ? len : (r == 1) ? int'($urandom_range(1, len)) : len + int'($urandom_range(1, 5));
        do_frame(nrd, 1'($urandom_range(0, 1)));
      end
    end

    // Reset in the middle of a transfer.
    push(2, 50);
    arb_wait(ok);
    if (ok) begin
      ptr_sfifo_rd = 1'b1;
      @(negedge clk);
      ptr_sfifo_rd = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        sfifo_rd = 1'b1;
      end
    end
    @(negedge clk);
    #2;
    rstn = 1'b0;
    sfifo_rd = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'(0));
    chk("mid_rst_empty", 32'(ptr_sfifo_empty), 32'(1));
    chk("mid_rst_strobes", 32'({port_rd, port_ptr_rd}), 32'(0));
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    push(3, 7); push(0, 9);
    do_frame(9, 1'b0); do_frame(7, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
